// File: rtl/flappy_pkg.sv
// Shared types and constants for the flappy game-logic blocks.
package flappy_pkg;

  typedef enum logic [1:0] {
    READY = 2'd0,
    PLAY  = 2'd1,
    DYING = 2'd2,
    OVER  = 2'd3
  } game_state_t;

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  localparam int SCREEN_X_MAX = 639;
  localparam int FLOOR_Y_DEF  = 479;

  // Widen a 10-bit screen coordinate to a 12-bit signed value so that
  // left-edge subtractions go negative instead of wrapping.
  function automatic logic signed [11:0] ext12(input logic [9:0] v);
    return $signed({2'b00, v});
  endfunction

endpackage

// File: rtl/pipe_hit_check.sv
// Combinational collision / pass detection between the bird and one pipe.
// All arithmetic is 12-bit signed on zero-extended 10-bit coordinates.
module pipe_hit_check
  import flappy_pkg::*;
#(
  parameter int PIPE_HALF_W = 16,
  parameter int GAP_HALF    = 40,
  parameter int FLOOR_Y     = FLOOR_Y_DEF
) (
  input  logic [9:0] bird_x_i,
  input  logic [9:0] bird_y_i,
  input  logic [9:0] bird_s_i,
  input  logic [9:0] pipe_x_i,
  input  logic [9:0] pipe_y_i,
  output logic       hit_o,
  output logic       passed_o
);

  localparam logic signed [11:0] PHW = 12'(PIPE_HALF_W);
  localparam logic signed [11:0] GH  = 12'(GAP_HALF);
  localparam logic signed [11:0] FLY = 12'(FLOOR_Y);

  logic signed [11:0] bx, by, bs, px, py;
  logic signed [11:0] dx, adx;
  logic               x_overlap, out_of_gap, on_floor;

  assign bx = ext12(bird_x_i);
  assign by = ext12(bird_y_i);
  assign bs = ext12(bird_s_i);
  assign px = ext12(pipe_x_i);
  assign py = ext12(pipe_y_i);

  // Overlap, gap and floor tests on the signed operands.
  always_comb begin
    dx         = bx - px;
    adx        = (dx < 0) ? -dx : dx;
    x_overlap  = (adx <= bs + PHW);
    out_of_gap = (by - bs < py - GH) || (by + bs > py + GH);
    on_floor   = (by + bs >= FLY);
    hit_o      = (x_overlap && out_of_gap) || on_floor;
    passed_o   = (px + PHW) < (bx - bs);
  end

endmodule

// File: rtl/pipe_score_ctrl.sv
// Game state machine, death timer and score counter for the pipe mover.
// Optional high-score register enabled by defining PIPE_SCORE_HIGH_SCORE_EN.
module pipe_score_ctrl
  import flappy_pkg::*;
#(
  parameter int PIPE_HALF_W  = 16,
  parameter int GAP_HALF     = 40,
  parameter int FLOOR_Y      = FLOOR_Y_DEF,
  parameter int DEATH_FRAMES = 60,
  parameter int SCORE_W      = 27
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic [7:0]         keycode,
  input  logic [9:0]         BirdX,
  input  logic [9:0]         BirdY,
  input  logic [9:0]         BirdS,
  input  logic [9:0]         PipeX,
  input  logic [9:0]         PipeY,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         game_state,
  output logic               freeze,
  output logic               pass_pulse,
  output logic [SCORE_W-1:0] high_score
);

  localparam int                 CNT_W     = $clog2(DEATH_FRAMES + 1);
  localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(DEATH_FRAMES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  game_state_t        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               armed_q, armed_d;
  logic               pulse_q, pulse_d;
  logic               hit, passed;
  logic               death_done;

  pipe_hit_check #(
    .PIPE_HALF_W (PIPE_HALF_W),
    .GAP_HALF    (GAP_HALF),
    .FLOOR_Y     (FLOOR_Y)
  ) u_hit_check (
    .bird_x_i (BirdX),
    .bird_y_i (BirdY),
    .bird_s_i (BirdS),
    .pipe_x_i (PipeX),
    .pipe_y_i (PipeY),
    .hit_o    (hit),
    .passed_o (passed)
  );

  assign death_done = (state_q == DYING) && (cnt_q == '0);

  // Next-state, death timer and scoring decisions for the current frame.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    score_d = score_q;
    armed_d = armed_q;
    pulse_d = 1'b0;
    unique case (state_q)
      READY: begin
        if (keycode == KEY_W) state_d = PLAY;
      end
      PLAY: begin
        if (hit) begin
          state_d = DYING;
          cnt_d   = CNT_LOAD;
        end else if (passed) begin
          if (armed_q) begin
            armed_d = 1'b0;
            if (score_q != SCORE_MAX) begin
              score_d = score_q + 1'b1;
              pulse_d = 1'b1;
            end
          end
        end else begin
          // Pipe is back to the right of the bird: allow the next pass.
          armed_d = 1'b1;
        end
      end
      DYING: begin
        if (cnt_q == '0) state_d = OVER;
        else             cnt_d   = cnt_q - 1'b1;
      end
      OVER: begin
        if (keycode == KEY_SPACE) begin
          state_d = READY;
          score_d = '0;
          armed_d = 1'b1;
        end
      end
      default: state_d = READY;
    endcase
  end

  // Frame-rate state register with synchronous reset.
  always_ff @(posedge frame_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (Reset) begin
      state_q <= READY;
      cnt_q   <= '0;
      score_q <= '0;
      armed_q <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      score_q <= score_d;
      armed_q <= armed_d;
      pulse_q <= pulse_d;
    end
  end

  assign score      = score_q;
  assign game_state = state_q;
  assign freeze     = (state_q != PLAY);
  assign pass_pulse = pulse_q;

`ifdef PIPE_SCORE_HIGH_SCORE_EN
  logic [SCORE_W-1:0] high_q, high_d;

  // Capture the finished game's score if it beats the record.
  always_comb begin
    high_d = high_q;
    if (death_done && (score_q > high_q)) high_d = score_q;
  end

  // High-score register, cleared only by reset.
  always_ff @(posedge frame_clk) begin
    if (Reset) high_q <= '0;
    else       high_q <= high_d;
  end

  assign high_score = high_q;
`else
  logic unused_death_done;
  assign unused_death_done = death_done;
  assign high_score        = '0;
`endif

endmodule
